// File: rtl/matrix_buffer_if.sv
// Write port and whole-matrix read stream bundle for matrix_buffer.
// master = producer/consumer side, slave = the buffer itself.
interface matrix_buffer_if #(
    parameter int WIDTH = 8,
    parameter int MW    = 2,
    parameter int EW    = 2
);
    logic                wr_valid;
    logic                wr_ready;
    logic [MW+EW-1:0]    wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic                rd_start;
    logic [MW-1:0]       rd_matrix;
    logic                rd_busy;
    logic                rd_valid;
    logic                rd_ready;
    logic [WIDTH-1:0]    rd_data;
    logic [EW-1:0]       rd_index;
    logic                rd_last;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_start, rd_matrix, rd_ready,
        input  wr_ready, rd_busy, rd_valid, rd_data, rd_index, rd_last
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_start, rd_matrix, rd_ready,
        output wr_ready, rd_busy, rd_valid, rd_data, rd_index, rd_last
    );
endinterface

// File: rtl/matrix_buffer.sv
// Matrix store with random-access writes and a streamed whole-matrix read.
// Optional MATRIX_BUFFER_LOCK_EN blocks writes into the matrix being streamed.
module matrix_buffer #(
    parameter int WIDTH        = 8,
    parameter int NUM_MATRICES = 4,
    parameter int ELEMS        = 4
) (
    input logic             clk,
    input logic             rst,
    matrix_buffer_if.slave  bus
);
    localparam int MW    = $clog2(NUM_MATRICES);
    localparam int EW    = $clog2(ELEMS);
    localparam int DEPTH = NUM_MATRICES * ELEMS;

    typedef enum logic {IDLE, STREAM} state_e;

    state_e            state_q;
    logic [MW-1:0]     mat_q;
    logic [EW-1:0]     idx_q;
    logic [EW-1:0]     idx_d;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic [WIDTH-1:0]  rd_data_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [MW+EW-1:0]  fetch_addr_d;
    logic              wr_en;

`ifdef MATRIX_BUFFER_LOCK_EN
    assign bus.wr_ready = !((state_q == STREAM) && (bus.wr_addr[MW+EW-1:EW] == mat_q));
`else
    assign bus.wr_ready = 1'b1;
`endif

    assign wr_en        = bus.wr_valid && bus.wr_ready;
    assign bus.rd_busy  = (state_q == STREAM);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_index = idx_q;
    assign bus.rd_last  = rd_last_q;

    always_comb begin
        idx_d        = idx_q + EW'(1);
        fetch_addr_d = (state_q == IDLE) ? {bus.rd_matrix, {EW{1'b0}}} : {mat_q, idx_d};
    end

    // Fetch reads mem_q before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q    <= IDLE;
            mat_q      <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[bus.wr_addr] <= bus.wr_data;
            end
            case (state_q)
                IDLE: begin
                    if (bus.rd_start) begin
                        state_q    <= STREAM;
                        mat_q      <= bus.rd_matrix;
                        idx_q      <= '0;
                        rd_valid_q <= 1'b1;
                        rd_last_q  <= 1'b0;
                        rd_data_q  <= mem_q[fetch_addr_d];
                    end
                end
                STREAM: begin
                    if (bus.rd_ready) begin
                        if (idx_q == EW'(ELEMS - 1)) begin
                            state_q    <= IDLE;
                            idx_q      <= '0;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            rd_data_q  <= '0;
                        end else begin
                            idx_q     <= idx_d;
                            rd_last_q <= (idx_d == EW'(ELEMS - 1));
                            rd_data_q <= mem_q[fetch_addr_d];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_matrix_buffer;
    localparam int W  = 8;
    localparam int NM = 4;
    localparam int E  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    matrix_buffer_if #(.WIDTH(W), .MW(2), .EW(2)) bus ();

    matrix_buffer #(.WIDTH(W), .NUM_MATRICES(NM), .ELEMS(E)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: memory array plus "which element of which matrix is on the bus".
    logic [W-1:0] m_mem [NM*E];
    bit           m_stream = 1'b0;
    int           m_mat    = 0;
    int           m_idx    = 0;
    logic [W-1:0] m_data   = '0;

    function automatic logic exp_wr_ready();
`ifdef MATRIX_BUFFER_LOCK_EN
        return !(m_stream && (int'(bus.wr_addr) / E == m_mat));
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        bit wr_ok;
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_stream = 1'b0;
            m_idx    = 0;
            m_data   = '0;
        end else begin
            wr_ok = bus.wr_valid && exp_wr_ready();
            if (m_stream) begin
                if (bus.rd_ready) begin
                    if (m_idx == E - 1) begin
                        m_stream = 1'b0;
                        m_idx    = 0;
                        m_data   = '0;
                    end else begin
                        m_idx  = m_idx + 1;
                        m_data = m_mem[m_mat * E + m_idx];
                    end
                end
            end else if (bus.rd_start) begin
                m_stream = 1'b1;
                m_mat    = int'(bus.rd_matrix);
                m_idx    = 0;
                m_data   = m_mem[m_mat * E];
            end
            if (wr_ok) m_mem[bus.wr_addr] = bus.wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("model_rd_valid", 32'(bus.rd_valid), 32'(m_stream));
            chk("model_rd_busy",  32'(bus.rd_busy),  32'(m_stream));
            chk("model_rd_data",  32'(bus.rd_data),  32'(m_data));
            chk("model_rd_index", 32'(bus.rd_index), 32'(m_idx));
            chk("model_rd_last",  32'(bus.rd_last),  32'(m_stream && m_idx == E - 1));
            chk("model_wr_ready", 32'(bus.wr_ready), 32'(exp_wr_ready()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic start_m1();
        bus.rd_start  = 1'b1;
        bus.rd_matrix = 2'd1;
        cyc();
        bus.rd_start  = 1'b0;
    endtask

    initial begin
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_start  = 1'b0;
        bus.rd_matrix = '0;
        bus.rd_ready  = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_rd_data",  32'(bus.rd_data),  32'd0);
        chk("reset_wr_ready", 32'(bus.wr_ready), 32'd1);

        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 4'(4 + i);
            bus.wr_data  = 8'(8'h11 * (i + 1));
            cyc();
        end
        bus.wr_valid = 1'b0;

        // Plain stream of matrix 1
        start_m1();
        bus.rd_ready = 1'b1;
        chk("s1_e0", 32'(bus.rd_data), 32'h11);
        chk("s1_i0", 32'(bus.rd_index), 32'd0);
        cyc();
        chk("s1_e1", 32'(bus.rd_data), 32'h22);
        cyc();
        chk("s1_e2", 32'(bus.rd_data), 32'h33);
        chk("s1_last2", 32'(bus.rd_last), 32'd0);
        cyc();
        chk("s1_e3", 32'(bus.rd_data), 32'h44);
        chk("s1_last3", 32'(bus.rd_last), 32'd1);
        cyc();
        chk("s1_busy_end", 32'(bus.rd_busy), 32'd0);
        chk("s1_valid_end", 32'(bus.rd_valid), 32'd0);

        // Backpressure on element 1, with an ignored rd_start for matrix 2
        start_m1();
        bus.rd_ready = 1'b1;
        cyc();
        bus.rd_ready  = 1'b0;
        bus.rd_start  = 1'b1;
        bus.rd_matrix = 2'd2;
        for (int k = 0; k < 3; k++) begin
            chk("hold_data", 32'(bus.rd_data), 32'h22);
            chk("hold_index", 32'(bus.rd_index), 32'd1);
            if (k < 2) cyc();
        end
        bus.rd_ready = 1'b1;
        cyc();
        chk("after_hold", 32'(bus.rd_data), 32'h33);
        bus.rd_start = 1'b0;
        cyc();
        chk("hold_last", 32'(bus.rd_data), 32'h44);
        bus.rd_start = 1'b1;
        cyc();
        chk("start_on_last_ignored", 32'(bus.rd_busy), 32'd0);
        bus.rd_start = 1'b0;

`ifdef MATRIX_BUFFER_LOCK_EN
        start_m1();
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd6;
        bus.wr_data  = 8'h66;
        #1;
        chk("lock_blocked", 32'(bus.wr_ready), 32'd0);
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        chk("lock_released", 32'(bus.wr_ready), 32'd1);
        cyc();
        bus.wr_valid = 1'b0;
        start_m1();
        cyc();
        cyc();
        chk("lock_write_done", 32'(bus.rd_data), 32'h66);
        cyc();
        cyc();
`else
        start_m1();
        bus.rd_ready = 1'b1;
        cyc();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd7;
        bus.wr_data  = 8'h99;
        cyc();
        bus.wr_valid = 1'b0;
        chk("live_e2", 32'(bus.rd_data), 32'h33);
        cyc();
        chk("live_e3", 32'(bus.rd_data), 32'h99);
        cyc();
`endif

        // Reset mid-stream
        start_m1();
        bus.rd_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus.rd_busy), 32'd0);
        start_m1();
        for (int k = 0; k < 4; k++) begin
            chk("rst_zero", 32'(bus.rd_data), 32'd0);
            chk("rst_valid_z", 32'(bus.rd_valid), 32'd1);
            cyc();
        end

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.wr_valid  = ($urandom_range(0, 1) == 1);
            bus.wr_addr   = 4'($urandom_range(0, 15));
            bus.wr_data   = 8'($urandom);
            bus.rd_start  = ($urandom_range(0, 4) == 0);
            bus.rd_matrix = 2'($urandom_range(0, 3));
            bus.rd_ready  = ($urandom_range(0, 9) < 7);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
